// File: rtl/game_state_controller.sv
// Breakout per-frame sequencer: paddle moves one cycle after FRAME_DONE,
// ball, lives and game phase one cycle later.
module game_state_controller #(
    parameter int PLAY_X_MIN  = 24,
    parameter int PLAY_X_MAX  = 776,
    parameter int PLAY_Y_MIN  = 24,
    parameter int PADDLE_Y    = 560,
    parameter int SCREEN_H    = 600,
    parameter int PADDLE_LEN  = 64,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2,
    parameter int START_LIVES = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FRAME_DONE,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_SERVE,
    output logic [9:0] PADDLE_X_PIXEL,
    output logic [9:0] BALL_X_PIXEL,
    output logic [9:0] BALL_Y_PIXEL,
    output logic [1:0] LIVES_LEFT,
    output logic       SERVING,
    output logic       GAME_OVER
);

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_PAD  = 2'd1;
    localparam logic [1:0] PH_BALL = 2'd2;

    localparam logic signed [10:0] X_MIN   = 11'(PLAY_X_MIN);
    localparam logic signed [10:0] X_MAX   = 11'(PLAY_X_MAX);
    localparam logic signed [10:0] Y_MIN   = 11'(PLAY_Y_MIN);
    localparam logic signed [10:0] PAD_Y   = 11'(PADDLE_Y);
    localparam logic signed [10:0] SCR_H   = 11'(SCREEN_H);
    localparam logic signed [10:0] P_LEN   = 11'(PADDLE_LEN);
    localparam logic signed [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic signed [10:0] P_STEP  = 11'(PADDLE_STEP);
    localparam logic signed [10:0] B_STEP  = 11'(BALL_STEP);
    localparam logic signed [10:0] PAD_MAX = 11'(PLAY_X_MAX - PADDLE_LEN);
    localparam logic signed [10:0] BX_MAX  = 11'(PLAY_X_MAX - BALL_SIZE);
    localparam logic signed [10:0] HIT_Y   = 11'(PADDLE_Y - BALL_SIZE);

    localparam logic [9:0] PAD_HOME =
        10'((PLAY_X_MIN + PLAY_X_MAX - PADDLE_LEN) / 2);
    localparam logic [9:0] PARK_OFS = 10'((PADDLE_LEN - BALL_SIZE) / 2);
    localparam logic [9:0] PARK_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic       btn_l_q;
    logic       btn_r_q;
    logic       btn_s_q;
    logic [9:0] paddle_q;
    logic [9:0] paddle_d;
    logic [9:0] ball_x_q;
    logic [9:0] ball_x_d;
    logic [9:0] ball_y_q;
    logic [9:0] ball_y_d;
    logic [1:0] lives_q;
    logic [1:0] lives_d;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       dir_x_q;
    logic       dir_x_d;
    logic       dir_y_q;
    logic       dir_y_d;

    logic              take;
    logic [9:0]        park_x;
    logic signed [10:0] pad_s;
    logic signed [10:0] pad_l;
    logic signed [10:0] pad_r;
    logic signed [10:0] bx_s;
    logic signed [10:0] by_s;
    logic signed [10:0] nx;
    logic signed [10:0] ny;

    // A pulse landing while the paddle update is pending is dropped.
    assign take = FRAME_DONE && (phase_q != PH_PAD);

    always_comb begin
        phase_d = PH_IDLE;
        if (take) begin
            phase_d = PH_PAD;
        end else if (phase_q == PH_PAD) begin
            phase_d = PH_BALL;
        end
    end

    assign pad_s = $signed({1'b0, paddle_q});
    assign pad_l = pad_s - P_STEP;
    assign pad_r = pad_s + P_STEP;

    always_comb begin
        paddle_d = paddle_q;
        if (btn_l_q && !btn_r_q) begin
            paddle_d = (pad_l < X_MIN) ? X_MIN[9:0] : pad_l[9:0];
        end else if (btn_r_q && !btn_l_q) begin
            paddle_d = (pad_r > PAD_MAX) ? PAD_MAX[9:0] : pad_r[9:0];
        end
    end

    assign park_x = paddle_q + PARK_OFS;
    assign bx_s   = $signed({1'b0, ball_x_q});
    assign by_s   = $signed({1'b0, ball_y_q});

    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        state_d  = state_q;
        lives_d  = lives_q;
        nx = dir_x_q ? (bx_s + B_STEP) : (bx_s - B_STEP);
        ny = dir_y_q ? (by_s + B_STEP) : (by_s - B_STEP);
        case (state_q)
            ST_SERVE: begin
                ball_x_d = park_x;
                ball_y_d = PARK_Y;
                if (btn_s_q) begin
                    state_d = ST_PLAY;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (nx < X_MIN) begin
                    nx      = X_MIN;
                    dir_x_d = 1'b1;
                end else if (nx + B_SIZE > X_MAX) begin
                    nx      = BX_MAX;
                    dir_x_d = 1'b0;
                end
                if (ny < Y_MIN) begin
                    ny      = Y_MIN;
                    dir_y_d = 1'b1;
                end
                // Paddle test uses the paddle already moved this frame.
                if (dir_y_d
                    && (by_s + B_SIZE <= PAD_Y)
                    && (ny + B_SIZE > PAD_Y)
                    && (nx + B_SIZE > pad_s)
                    && (nx < pad_s + P_LEN)) begin
                    ny      = HIT_Y;
                    dir_y_d = 1'b0;
                end
                if (ny >= SCR_H) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d  = ST_SERVE;
                        ball_x_d = park_x;
                        ball_y_d = PARK_Y;
                        dir_x_d  = 1'b1;
                        dir_y_d  = 1'b0;
                    end
                end else begin
                    ball_x_d = nx[9:0];
                    ball_y_d = ny[9:0];
                end
            end
            ST_OVER: begin
                lives_d = 2'd0;
                if (btn_s_q) begin
                    lives_d  = LIVES_INIT;
                    state_d  = ST_SERVE;
                    ball_x_d = park_x;
                    ball_y_d = PARK_Y;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q  <= PH_IDLE;
            btn_l_q  <= 1'b0;
            btn_r_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            paddle_q <= PAD_HOME;
            ball_x_q <= PAD_HOME + PARK_OFS;
            ball_y_q <= PARK_Y;
            lives_q  <= LIVES_INIT;
            state_q  <= ST_SERVE;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (take) begin
                btn_l_q <= BTN_LEFT;
                btn_r_q <= BTN_RIGHT;
                btn_s_q <= BTN_SERVE;
            end
            if (phase_q == PH_PAD && state_q != ST_OVER) begin
                paddle_q <= paddle_d;
            end
            if (phase_q == PH_BALL) begin
                ball_x_q <= ball_x_d;
                ball_y_q <= ball_y_d;
                lives_q  <= lives_d;
                state_q  <= state_d;
                dir_x_q  <= dir_x_d;
                dir_y_q  <= dir_y_d;
            end
        end
    end

    assign PADDLE_X_PIXEL = paddle_q;
    assign BALL_X_PIXEL   = ball_x_q;
    assign BALL_Y_PIXEL   = ball_y_q;
    assign LIVES_LEFT     = lives_q;
    assign SERVING        = (state_q == ST_SERVE);
    assign GAME_OVER      = (state_q == ST_OVER);

endmodule
